ifm_frame_sorter: RTL and testbench
===================================

# ifm_frame_sorter

Sequencer in the `sys_clk` domain for the RX ingress FIFO set. It pops one good/bad verdict per frame from the info FIFO, then drains that frame's beats from the data FIFO. Good frames are forwarded into the good FIFO, which feeds the MAC-side AXI-Stream. Bad frames are read out and discarded.

## Interface
Parameters:
- `C_SETTLE_CYCLES`, default 4: wait cycles between the info pop and the first data read. This covers pointer-synchronizer skew between the info and data FIFOs. Range 0–15.
- `C_STAT_WIDTH`, default 32: width of the frame counters.

Ports:
- `sys_clk` in 1: single clock; all logic in this domain.
- `sys_reset` in 1: asynchronous, active-high reset.
- `ctrl_enable` in 1: when high, the block may start new frames.
- `info_fifo_empty` in 1: verdict FIFO empty.
- `info_fifo_rdata` in 1: head verdict, 1 = good frame. Valid while `info_fifo_empty` is low (FWFT).
- `info_fifo_rden` out 1: pops the verdict.
- `data_fifo_rdata` in 73: head beat {tlast[72], tkeep[71:64], tdata[63:0]}, FWFT.
- `data_fifo_rden` out 1: pops the head beat.
- `good_fifo_afull` in 1: good FIFO prog_full.
- `good_fifo_wdata` out 73: beat to the good FIFO, same packing as `data_fifo_rdata`.
- `good_fifo_wren` out 1: good FIFO write strobe.
- `busy` out 1: high in any state other than IDLE.
- `stat_good_frames` out `C_STAT_WIDTH`: forwarded frame count. Present only with the macro.
- `stat_bad_frames` out `C_STAT_WIDTH`: dropped frame count. Present only with the macro.

## Operation
- Upstream contract:
  - A verdict is written to the info FIFO only after the frame's last beat has been written to the data FIFO.
  - Therefore, once a verdict has been popped and the settle wait has elapsed, the whole frame is readable.
  - The block never checks data FIFO emptiness.
- States: IDLE, SETTLE, XFER.
- IDLE: if `ctrl_enable` is high and `info_fifo_empty` is low, then in that cycle:
  - assert `info_fifo_rden`;
  - latch `good_q <= info_fifo_rdata`;
  - load `settle_cnt <= C_SETTLE_CYCLES`;
  - go to SETTLE, or straight to XFER if `C_SETTLE_CYCLES` = 0.
- SETTLE: decrement `settle_cnt` each cycle. Go to XFER in the cycle it reaches 0, so SETTLE lasts exactly `C_SETTLE_CYCLES` cycles.
- XFER, read enable:
  - `data_fifo_rden = ~good_q | ~good_fifo_afull`. A bad frame drains at full rate regardless of backpressure.
- XFER, forwarding:
  - Registered output stage: `good_fifo_wren <= data_fifo_rden & good_q`; `good_fifo_wdata <= data_fifo_rdata`.
  - `good_fifo_wdata` updates only when `data_fifo_rden` is high, and is otherwise held.
- XFER, frame end:
  - A popped beat with bit 72 set ends the frame; the next state is IDLE.
  - A single-beat frame is legal.
- `ctrl_enable` low only blocks the IDLE→SETTLE transition. A frame already in progress always completes.
- Backpressure:
  - The prog_full threshold (256 of 1024) absorbs the one-cycle write lag, so no write is ever lost.
  - `good_fifo_afull` is sampled combinationally in XFER.
- Reset: all state, counters and outputs clear asynchronously and the state returns to IDLE.
  - Mid-frame reset abandons the frame.
  - `sys_reset` must be asserted whenever the FIFOs' `rx_reset` is, so the verdicts and data stay aligned.

## Timing
- Reset values:
  - `info_fifo_rden`, `data_fifo_rden`, `good_fifo_wren` = 0.
  - `good_fifo_wdata` = 0, `busy` = 0, stat counters = 0.
- Let cycle 0 be the IDLE cycle in which the verdict is popped. Then:
  - the first `data_fifo_rden` occurs at cycle `C_SETTLE_CYCLES+1`;
  - the first `good_fifo_wren` occurs at cycle `C_SETTLE_CYCLES+2`.
- Throughput is one beat per cycle in XFER when not backpressured.
- Inter-frame gap: the tlast pop cycle is followed by IDLE at the next cycle. IDLE can pop the next verdict in that same cycle. The minimum gap between the last read of one frame and the first read of the next is `C_SETTLE_CYCLES+1` idle cycles.
- `busy` is registered from the state: high from cycle 1 through the cycle after the tlast pop.

## Configuration
- `IFM_FRAME_STATS_EN` defined:
  - `stat_good_frames` or `stat_bad_frames` increments (wrapping modulo 2^`C_STAT_WIDTH`) in the cycle after the tlast beat is popped, selected by `good_q`.
- `IFM_FRAME_STATS_EN` undefined:
  - the counters and both stat ports are removed;
  - all other behaviour is identical.

## Test plan
- Good frame of 3 beats (tdata 0x11.., 0x22.., 0x33.., tkeep 0xFF, 0xFF, 0x0F, tlast on beat 3), verdict=1, `C_SETTLE_CYCLES`=4 -> exactly 3 `good_fifo_wren` pulses at cycles 6, 7 and 8, with identical 73-bit words; state back in IDLE at cycle 8.
- Bad frame of 5 beats, verdict=0, with `good_fifo_afull` held high -> 5 consecutive `data_fifo_rden` pulses; zero `good_fifo_wren`; the following good frame is forwarded intact.
- Good 8-beat frame with `good_fifo_afull` high for cycles 3–6 of XFER -> reads stall during those cycles; no beat is dropped or duplicated; the output sequence equals the input.
- `ctrl_enable` low with 2 verdicts queued -> no `info_fifo_rden`. Drop `ctrl_enable` mid-frame -> the current frame completes and no new verdict is popped.
- Assert `sys_reset` in the middle of a good frame's XFER -> all outputs are 0 immediately, `busy`=0, and the state is IDLE after release.
- With `IFM_FRAME_STATS_EN` defined: 10 back-to-back single-beat frames alternating good/bad -> `stat_good_frames`=5, `stat_bad_frames`=5. Preload the good count to 2^32−1; one more good frame -> the count wraps to 0.

Source files
------------

// File: rtl/ifm_frame_sorter.sv
// ifm_frame_sorter: pops one good/bad verdict per frame from the info FIFO,
// waits C_SETTLE_CYCLES for pointer-sync skew, then drains that frame's
// beats from the data FIFO. Good frames go to the good FIFO; bad frames are
// read and discarded.
// Optional feature macro: IFM_FRAME_STATS_EN adds good/bad frame counters.
module ifm_frame_sorter #(
  parameter int unsigned C_SETTLE_CYCLES = 4,
  parameter int unsigned C_STAT_WIDTH    = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset,
  input  logic                    ctrl_enable,
  input  logic                    info_fifo_empty,
  input  logic                    info_fifo_rdata,
  output logic                    info_fifo_rden,
  input  logic [72:0]             data_fifo_rdata,
  output logic                    data_fifo_rden,
  input  logic                    good_fifo_afull,
  output logic [72:0]             good_fifo_wdata,
  output logic                    good_fifo_wren,
  output logic                    busy
`ifdef IFM_FRAME_STATS_EN
  ,
  output logic [C_STAT_WIDTH-1:0] stat_good_frames,
  output logic [C_STAT_WIDTH-1:0] stat_bad_frames
`endif
);

  localparam logic [3:0] LP_SETTLE = 4'(C_SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_XFER
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_good;
  logic [3:0]  r_settle_cnt;
  logic        r_busy;
  logic        r_wren;
  logic [72:0] r_wdata;
  logic        w_start;
  logic        w_rd;
  logic        w_last;

  assign w_start = (r_state == S_IDLE) & ctrl_enable & ~info_fifo_empty;
  // Bad frames drain at full rate; only good frames honour backpressure.
  assign w_rd    = (r_state == S_XFER) & (~r_good | ~good_fifo_afull);
  assign w_last  = w_rd & data_fifo_rdata[72];

  // The pop strobe is combinational from IDLE, so it is masked during reset
  // to keep the verdict FIFO untouched while the block is held.
  assign info_fifo_rden  = w_start & ~sys_reset;
  assign data_fifo_rden  = w_rd;
  assign good_fifo_wren  = r_wren;
  assign good_fifo_wdata = r_wdata;
  assign busy            = r_busy;

  // Next-state selection for the IDLE/SETTLE/XFER sequencer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (C_SETTLE_CYCLES == 0) ? S_XFER : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == 4'd1) begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, verdict latch, settle counter, busy flag and registered write stage.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state      <= S_IDLE;
      r_good       <= 1'b0;
      r_settle_cnt <= '0;
      r_busy       <= 1'b0;
      r_wren       <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_good       <= info_fifo_rdata;
        r_settle_cnt <= LP_SETTLE;
      end else if (r_state == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt - 4'd1;
      end
      // Covering the current state as well keeps busy high for the cycle
      // after the tlast pop, when the state is already back in IDLE.
      r_busy <= (w_state_nxt != S_IDLE) | (r_state != S_IDLE);
      r_wren <= w_rd & r_good;
      if (w_rd) begin
        r_wdata <= data_fifo_rdata;
      end
    end
  end

`ifdef IFM_FRAME_STATS_EN
  logic [C_STAT_WIDTH-1:0] r_stat_good;
  logic [C_STAT_WIDTH-1:0] r_stat_bad;

  assign stat_good_frames = r_stat_good;
  assign stat_bad_frames  = r_stat_bad;

  // Count each frame as its tlast beat is popped; counters wrap naturally.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_stat_good <= '0;
      r_stat_bad  <= '0;
    end else if (w_last) begin
      if (r_good) begin
        r_stat_good <= r_stat_good + 1'b1;
      end else begin
        r_stat_bad <= r_stat_bad + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifm_frame_sorter.sv
// Directed bench for ifm_frame_sorter with FWFT FIFO models for the info
// and data FIFOs and an event log of pops/writes stamped by cycle number.
module tb_ifm_frame_sorter;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        ctrl_enable;
  logic        info_fifo_empty;
  logic        info_fifo_rdata;
  logic        info_fifo_rden;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_rden;
  logic        good_fifo_afull;
  logic [72:0] good_fifo_wdata;
  logic        good_fifo_wren;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit          info_q[$];
  logic [72:0] data_q[$];
  int          ev_info[$];
  int          ev_rd[$];
  int          ev_wr[$];
  logic [72:0] ev_wd[$];
  bit          busy_log[0:4095];

  always #5 sys_clk = ~sys_clk;

`ifdef IFM_FRAME_STATS_EN
  logic [31:0] stat_good_frames;
  logic [31:0] stat_bad_frames;
  logic        n_info_rden;
  logic        n_data_rden;
  logic [72:0] n_wdata;
  logic        n_wren;
  logic        n_busy;
  logic [1:0]  n_stat_good;
  logic [1:0]  n_stat_bad;
`endif

  ifm_frame_sorter #(
    .C_SETTLE_CYCLES(4),
    .C_STAT_WIDTH   (32)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_reset       (sys_reset),
    .ctrl_enable     (ctrl_enable),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_rden  (info_fifo_rden),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_rden  (data_fifo_rden),
    .good_fifo_afull (good_fifo_afull),
    .good_fifo_wdata (good_fifo_wdata),
    .good_fifo_wren  (good_fifo_wren),
    .busy            (busy)
`ifdef IFM_FRAME_STATS_EN
    ,
    .stat_good_frames(stat_good_frames),
    .stat_bad_frames (stat_bad_frames)
`endif
  );

`ifdef IFM_FRAME_STATS_EN
  // Narrow-counter twin fed the same inputs, used to observe counter wrap.
  ifm_frame_sorter #(
    .C_SETTLE_CYCLES(4),
    .C_STAT_WIDTH   (2)
  ) dut_narrow (
    .sys_clk         (sys_clk),
    .sys_reset       (sys_reset),
    .ctrl_enable     (ctrl_enable),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_rden  (n_info_rden),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_rden  (n_data_rden),
    .good_fifo_afull (good_fifo_afull),
    .good_fifo_wdata (n_wdata),
    .good_fifo_wren  (n_wren),
    .busy            (n_busy),
    .stat_good_frames(n_stat_good),
    .stat_bad_frames (n_stat_bad)
  );
`endif

  function automatic logic [72:0] beat(input logic last, input logic [7:0] keep,
                                       input logic [63:0] d);
    return {last, keep, d};
  endfunction

  function automatic bit busy_at(input int c);
    if (c < 0 || c > 4095) return 1'b0;
    return busy_log[c];
  endfunction

  task automatic refresh();
    info_fifo_empty = (info_q.size() == 0);
    info_fifo_rdata = (info_q.size() != 0) ? info_q[0] : 1'b0;
    data_fifo_rdata = (data_q.size() != 0) ? data_q[0] : '0;
  endtask

  task automatic clear_ev();
    ev_info.delete(); ev_rd.delete(); ev_wr.delete(); ev_wd.delete();
  endtask

  // One clock: log outputs at the falling edge, then apply FIFO pops just
  // after the rising edge so the DUT samples the pre-pop head word.
  task automatic tick();
    bit si;
    bit sd;
    @(negedge sys_clk);
    if (!sys_reset) begin
      if (info_fifo_rden) ev_info.push_back(cyc);
      if (data_fifo_rden) ev_rd.push_back(cyc);
      if (good_fifo_wren) begin
        ev_wr.push_back(cyc);
        ev_wd.push_back(good_fifo_wdata);
      end
      if (cyc < 4096) busy_log[cyc] = busy;
    end
    si = info_fifo_rden;
    sd = data_fifo_rden;
    @(posedge sys_clk);
    cyc++;
    #1;
    if (si && info_q.size() != 0) void'(info_q.pop_front());
    if (sd && data_q.size() != 0) void'(data_q.pop_front());
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    sys_reset       = 1'b1;
    ctrl_enable     = 1'b1;
    good_fifo_afull = 1'b0;
    info_q.push_back(1'b1);
    refresh();
    ticks(2);
    checks++;
    if (info_fifo_rden !== 1'b0) begin
      failures++; $display("FAIL rst_info_rden got=%b exp=0", info_fifo_rden);
    end
    checks++;
    if ({data_fifo_rden, good_fifo_wren, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ctrl got rd=%b wr=%b busy=%b exp=0", data_fifo_rden, good_fifo_wren, busy);
    end
    checks++;
    if (good_fifo_wdata !== 73'd0) begin
      failures++; $display("FAIL rst_wdata got=%h exp=0", good_fifo_wdata);
    end
`ifdef IFM_FRAME_STATS_EN
    checks++;
    if (stat_good_frames !== 32'd0 || stat_bad_frames !== 32'd0) begin
      failures++;
      $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_good_frames, stat_bad_frames);
    end
`endif
    info_q.delete();
    ctrl_enable = 1'b0;
    refresh();
    sys_reset = 1'b0;
    ticks(2);
  endtask

  task automatic test_good_frame();
    logic [72:0] exp[3];
    int t0;
    exp[0] = beat(1'b0, 8'hFF, 64'h1111_1111_1111_1111);
    exp[1] = beat(1'b0, 8'hFF, 64'h2222_2222_2222_2222);
    exp[2] = beat(1'b1, 8'h0F, 64'h3333_3333_3333_3333);
    clear_ev();
    for (int i = 0; i < 3; i++) data_q.push_back(exp[i]);
    info_q.push_back(1'b1);
    refresh();
    ctrl_enable = 1'b1;
    ticks(20);
    ctrl_enable = 1'b0;
    t0 = (ev_info.size() != 0) ? ev_info[0] : -100;
    checks++;
    if (ev_info.size() != 1 || ev_rd.size() != 3 || ev_wr.size() != 3) begin
      failures++;
      $display("FAIL good_counts got pops=%0d reads=%0d writes=%0d exp=1/3/3",
               ev_info.size(), ev_rd.size(), ev_wr.size());
    end
    checks++;
    if (ev_rd.size() == 0 || ev_rd[0] != t0 + 5) begin
      failures++; $display("FAIL good_first_read got=%0d exp=%0d",
                           (ev_rd.size() != 0) ? ev_rd[0] - t0 : -1, 5);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ev_wr.size() || ev_wr[i] != t0 + 6 + i || ev_wd[i] !== exp[i]) begin
        failures++;
        $display("FAIL good_beat%0d got cyc=%0d data=%h exp cyc=%0d data=%h", i,
                 (i < ev_wr.size()) ? ev_wr[i] - t0 : -1,
                 (i < ev_wd.size()) ? ev_wd[i] : 73'd0, 6 + i, exp[i]);
      end
    end
    checks++;
    if ({busy_at(t0), busy_at(t0 + 1), busy_at(t0 + 8), busy_at(t0 + 9)} !== 4'b0110) begin
      failures++;
      $display("FAIL good_busy got c0..=%b%b c8..=%b%b exp=0110", busy_at(t0),
               busy_at(t0 + 1), busy_at(t0 + 8), busy_at(t0 + 9));
    end
  endtask

  task automatic test_bad_then_good();
    logic [72:0] g0;
    logic [72:0] g1;
    int t0;
    g0 = beat(1'b0, 8'hFF, 64'hC0C0_0000_0000_00C0);
    g1 = beat(1'b1, 8'h03, 64'hC1C1_0000_0000_00C1);
    clear_ev();
    good_fifo_afull = 1'b1;
    for (int i = 0; i < 5; i++) data_q.push_back(beat(i == 4, 8'hFF, 64'hB0 + 64'(i)));
    info_q.push_back(1'b0);
    data_q.push_back(g0);
    data_q.push_back(g1);
    info_q.push_back(1'b1);
    refresh();
    ctrl_enable = 1'b1;
    ticks(16);
    good_fifo_afull = 1'b0;
    ticks(10);
    ctrl_enable = 1'b0;
    t0 = (ev_info.size() != 0) ? ev_info[0] : -100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= ev_rd.size() || ev_rd[i] != t0 + 5 + i) begin
        failures++; $display("FAIL bad_read%0d got=%0d exp=%0d", i,
                             (i < ev_rd.size()) ? ev_rd[i] - t0 : -1, 5 + i);
      end
    end
    checks++;
    if (ev_rd.size() != 7 || ev_rd[5] != t0 + 16) begin
      failures++; $display("FAIL bad_good_stall got reads=%0d first_good=%0d exp=7/16",
                           ev_rd.size(), (ev_rd.size() > 5) ? ev_rd[5] - t0 : -1);
    end
    checks++;
    if (ev_wr.size() != 2 || ev_wd[0] !== g0 || ev_wd[1] !== g1) begin
      failures++; $display("FAIL bad_then_good_out got writes=%0d exp=2 (%h,%h)",
                           ev_wr.size(), g0, g1);
    end
  endtask

  task automatic test_backpressure();
    logic [72:0] exp[8];
    int t0;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      exp[i] = beat(i == 7, 8'hFF, 64'hD000_0000_0000_0000 + 64'(i));
      data_q.push_back(exp[i]);
    end
    clear_ev();
    info_q.push_back(1'b1);
    refresh();
    ctrl_enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      ctrl_enable     = 1'b0;
      good_fifo_afull = (k >= 7 && k <= 10);
    end
    t0 = (ev_info.size() != 0) ? ev_info[0] : -100;
    checks++;
    if (ev_rd.size() != 8 || ev_rd[1] != t0 + 6 || ev_rd[2] != t0 + 11) begin
      failures++; $display("FAIL bp_stall got reads=%0d r1=%0d r2=%0d exp=8/6/11",
                           ev_rd.size(), (ev_rd.size() > 1) ? ev_rd[1] - t0 : -1,
                           (ev_rd.size() > 2) ? ev_rd[2] - t0 : -1);
    end
    ok = (ev_wr.size() == 8);
    for (int i = 0; i < 8; i++) if (ok && ev_wd[i] !== exp[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL bp_sequence got writes=%0d exp=8 in order", ev_wr.size());
    end
  endtask

  task automatic test_enable();
    logic [72:0] e1;
    e1 = beat(1'b1, 8'hFF, 64'hE1);
    clear_ev();
    ctrl_enable = 1'b0;
    data_q.push_back(beat(1'b0, 8'hFF, 64'hE0));
    data_q.push_back(beat(1'b0, 8'hFF, 64'hE0E0));
    data_q.push_back(beat(1'b1, 8'hFF, 64'hE0E0E0));
    info_q.push_back(1'b1);
    data_q.push_back(e1);
    info_q.push_back(1'b1);
    refresh();
    ticks(10);
    checks++;
    if (ev_info.size() != 0) begin
      failures++; $display("FAIL en_low_pop got=%0d exp=0", ev_info.size());
    end
    ctrl_enable = 1'b1;
    tick();
    ctrl_enable = 1'b0;
    ticks(15);
    checks++;
    if (ev_info.size() != 1 || ev_wr.size() != 3 || info_q.size() != 1) begin
      failures++; $display("FAIL en_midframe got pops=%0d writes=%0d queued=%0d exp=1/3/1",
                           ev_info.size(), ev_wr.size(), info_q.size());
    end
    ctrl_enable = 1'b1;
    ticks(15);
    ctrl_enable = 1'b0;
    checks++;
    if (ev_wr.size() != 4 || ev_wd[3] !== e1) begin
      failures++; $display("FAIL en_resume got writes=%0d exp=4 last=%h", ev_wr.size(), e1);
    end
  endtask

  task automatic test_reset_mid();
    logic [72:0] a5;
    int t0;
    a5 = beat(1'b1, 8'h01, 64'hA5);
    clear_ev();
    for (int i = 0; i < 8; i++) data_q.push_back(beat(i == 7, 8'hFF, 64'hF0 + 64'(i)));
    info_q.push_back(1'b1);
    info_q.push_back(1'b1);
    refresh();
    ctrl_enable = 1'b1;
    ticks(7);
    checks++;
    if (good_fifo_wren !== 1'b1) begin
      failures++; $display("FAIL rmid_pre_wren got=%b exp=1", good_fifo_wren);
    end
    sys_reset = 1'b1;
    #1;
    checks++;
    if ({info_fifo_rden, data_fifo_rden, good_fifo_wren, busy} !== 4'b0000 ||
        good_fifo_wdata !== 73'd0) begin
      failures++;
      $display("FAIL rmid_outputs got ir=%b dr=%b wr=%b busy=%b wd=%h exp=0",
               info_fifo_rden, data_fifo_rden, good_fifo_wren, busy, good_fifo_wdata);
    end
    info_q.delete();
    data_q.delete();
    refresh();
    ticks(2);
    sys_reset = 1'b0;
    clear_ev();
    data_q.push_back(a5);
    info_q.push_back(1'b1);
    refresh();
    ticks(12);
    ctrl_enable = 1'b0;
    t0 = (ev_info.size() != 0) ? ev_info[0] : -100;
    checks++;
    if (ev_wr.size() != 1 || ev_wr[0] != t0 + 6 || ev_wd[0] !== a5) begin
      failures++; $display("FAIL rmid_after got writes=%0d at=%0d exp=1 at 6 data=%h",
                           ev_wr.size(), (ev_wr.size() != 0) ? ev_wr[0] - t0 : -1, a5);
    end
  endtask

  task automatic test_back_to_back();
    logic [72:0] w1;
    logic [72:0] w3;
    w1 = beat(1'b1, 8'hFF, 64'h01);
    w3 = beat(1'b1, 8'hFF, 64'h03);
    clear_ev();
    data_q.push_back(w1);
    info_q.push_back(1'b1);
    data_q.push_back(beat(1'b1, 8'hFF, 64'h02));
    info_q.push_back(1'b0);
    data_q.push_back(w3);
    info_q.push_back(1'b1);
    refresh();
    ctrl_enable = 1'b1;
    ticks(25);
    ctrl_enable = 1'b0;
    checks++;
    if (ev_info.size() != 3 || ev_info[1] != ev_info[0] + 6 || ev_info[2] != ev_info[1] + 6) begin
      failures++; $display("FAIL b2b_pop_spacing got pops=%0d gaps=%0d,%0d exp=3 6,6",
                           ev_info.size(),
                           (ev_info.size() > 1) ? ev_info[1] - ev_info[0] : -1,
                           (ev_info.size() > 2) ? ev_info[2] - ev_info[1] : -1);
    end
    checks++;
    if (ev_rd.size() != 3 || ev_rd[1] != ev_rd[0] + 6) begin
      failures++; $display("FAIL b2b_read_gap got reads=%0d gap=%0d exp=3 6", ev_rd.size(),
                           (ev_rd.size() > 1) ? ev_rd[1] - ev_rd[0] : -1);
    end
    checks++;
    if (ev_wr.size() != 2 || ev_wd[0] !== w1 || ev_wd[1] !== w3) begin
      failures++; $display("FAIL b2b_out got writes=%0d exp=2 (%h,%h)", ev_wr.size(), w1, w3);
    end
  endtask

`ifdef IFM_FRAME_STATS_EN
  task automatic test_stats();
    sys_reset = 1'b1;
    ticks(2);
    sys_reset = 1'b0;
    clear_ev();
    for (int i = 0; i < 10; i++) begin
      data_q.push_back(beat(1'b1, 8'hFF, 64'h5000 + 64'(i)));
      info_q.push_back((i % 2) == 0);
    end
    refresh();
    ctrl_enable = 1'b1;
    ticks(70);
    ctrl_enable = 1'b0;
    checks++;
    if (stat_good_frames !== 32'd5 || stat_bad_frames !== 32'd5) begin
      failures++; $display("FAIL stats_count got=%0d/%0d exp=5/5",
                           stat_good_frames, stat_bad_frames);
    end
    checks++;
    if (n_stat_good !== 2'd1 || n_stat_bad !== 2'd1) begin
      failures++; $display("FAIL stats_wrap got=%0d/%0d exp=1/1", n_stat_good, n_stat_bad);
    end
  endtask
`endif

  initial begin
    sys_reset       = 1'b1;
    ctrl_enable     = 1'b0;
    good_fifo_afull = 1'b0;
    refresh();
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_back_to_back();
`ifdef IFM_FRAME_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
